// File: rtl/mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_sequencer
// Brief    : Streams operand pairs into the pipelined mac as a dot product,
//            drains the pipeline and returns the result on a valid/ready port.
// Revision : 1.0
// ============================================================================
module mac_dot_sequencer #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_mode,
    input  logic             cmd_sat,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic [2:0]       mac_instruction,
    output logic [15:0]      mac_multiplier,
    output logic [15:0]      mac_multiplicand,
    output logic             mac_stall,
    input  logic [31:0]      mac_result,
    input  logic [7:0]       mac_protect,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [7:0]       res_protect,
    output logic             busy
);

    localparam int DW = $clog2(MAC_LAT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_CLRS  = 3'd2;
    localparam logic [2:0] S_SATS  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             sat_q, sat_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [7:0]       res_protect_q, res_protect_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            mode_q        <= 1'b0;
            sat_q         <= 1'b0;
            drain_q       <= '0;
            res_data_q    <= '0;
            res_protect_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            mode_q        <= mode_d;
            sat_q         <= sat_d;
            drain_q       <= drain_d;
            res_data_q    <= res_data_d;
            res_protect_q <= res_protect_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        len_d            = len_q;
        mode_d           = mode_q;
        sat_d            = sat_q;
        drain_d          = drain_q;
        res_data_d       = res_data_q;
        res_protect_d    = res_protect_q;
        // Zero-operand ACC is the bubble: it never disturbs the accumulator.
        mac_instruction  = {mode_q, 2'b10};
        mac_multiplier   = '0;
        mac_multiplicand = '0;
        mac_stall        = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    mode_d  = cmd_mode;
                    sat_d   = cmd_sat;
                    cnt_d   = '0;
                    state_d = (cmd_len == '0) ? S_CLRS : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mac_stall = !op_valid;
                if (op_valid) begin
                    mac_instruction  = (cnt_q == '0) ? {mode_q, 2'b01} : {mode_q, 2'b10};
                    mac_multiplicand = op_a;
                    mac_multiplier   = op_b;
                    cnt_d            = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = sat_q ? S_SATS : S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_CLRS: begin
                mac_stall       = 1'b0;
                mac_instruction = {mode_q, 2'b00};
                state_d         = S_DRAIN;
                drain_d         = '0;
            end
            S_SATS: begin
                mac_stall       = 1'b0;
                mac_instruction = {mode_q, 2'b11};
                state_d         = S_DRAIN;
                drain_d         = '0;
            end
            S_DRAIN: begin
                mac_stall = 1'b0;
                if (drain_q == DW'(MAC_LAT - 1)) begin
                    res_data_d    = mac_result;
                    res_protect_d = mac_protect;
                    state_d       = S_RESP;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign op_ready    = (state_q == S_ISSUE);
    assign res_valid   = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign res_data    = res_data_q;
    assign res_protect = res_protect_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_dot_sequencer
// Brief    : Directed bench for mac_dot_sequencer with a behavioural 3-stage mac.
// Revision : 1.0
// ============================================================================
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic        cmd_mode = 1'b0;
    logic        cmd_sat = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [2:0]  mac_instruction;
    logic [15:0] mac_multiplier;
    logic [15:0] mac_multiplicand;
    logic        mac_stall;
    logic [31:0] mac_result;
    logic [7:0]  mac_protect;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [7:0]  res_protect;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_dot_sequencer #(.LEN_W(8), .MAC_LAT(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_len          (cmd_len),
        .cmd_mode         (cmd_mode),
        .cmd_sat          (cmd_sat),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_a             (op_a),
        .op_b             (op_b),
        .mac_instruction  (mac_instruction),
        .mac_multiplier   (mac_multiplier),
        .mac_multiplicand (mac_multiplicand),
        .mac_stall        (mac_stall),
        .mac_result       (mac_result),
        .mac_protect      (mac_protect),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_protect      (res_protect),
        .busy             (busy)
    );

    // Behavioural mac: issue -> operand regs -> product regs -> accumulator.
    logic [2:0]         s1_i, s2_i;
    logic [15:0]        s1_a, s1_b;
    logic signed [31:0] s2_p;
    logic signed [15:0] s2_l1, s2_l0;
    logic [39:0]        acc;
    logic               acc_m;

    function automatic logic [39:0] sat40(input logic [39:0] v);
        if (v[39:31] == 9'h000 || v[39:31] == 9'h1FF) return v;
        return v[39] ? 40'hFF80000000 : 40'h007FFFFFFF;
    endfunction

    function automatic logic [19:0] sat20(input logic [19:0] v);
        if (v[19:15] == 5'h00 || v[19:15] == 5'h1F) return v;
        return v[19] ? 20'hF8000 : 20'h07FFF;
    endfunction

    function automatic logic [19:0] lane_op(input logic [1:0] op, input logic [19:0] a,
                                            input logic signed [15:0] p);
        logic [19:0] pe;
        pe = {{4{p[15]}}, p};
        case (op)
            2'b00:   return 20'h0;
            2'b01:   return pe;
            2'b10:   return a + pe;
            default: return sat20(a);
        endcase
    endfunction

    function automatic logic [39:0] mac_next(input logic [39:0] a, input logic [2:0] ins,
                                             input logic signed [31:0] p,
                                             input logic signed [15:0] l1,
                                             input logic signed [15:0] l0);
        logic [39:0] pe;
        if (ins[2]) return {lane_op(ins[1:0], a[39:20], l1), lane_op(ins[1:0], a[19:0], l0)};
        pe = {{8{p[31]}}, p};
        case (ins[1:0])
            2'b00:   return 40'h0;
            2'b01:   return pe;
            2'b10:   return a + pe;
            default: return sat40(a);
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_i <= 3'b010; s1_a <= '0; s1_b <= '0;
            s2_i <= 3'b010; s2_p <= '0; s2_l1 <= '0; s2_l0 <= '0;
            acc <= '0; acc_m <= 1'b0;
        end else if (!mac_stall) begin
            s1_i  <= mac_instruction;
            s1_a  <= mac_multiplicand;
            s1_b  <= mac_multiplier;
            s2_i  <= s1_i;
            s2_p  <= $signed(s1_a) * $signed(s1_b);
            s2_l1 <= $signed(s1_a[15:8]) * $signed(s1_b[15:8]);
            s2_l0 <= $signed(s1_a[7:0]) * $signed(s1_b[7:0]);
            acc   <= mac_next(acc, s2_i, s2_p, s2_l1, s2_l0);
            acc_m <= s2_i[2];
        end
    end

    assign mac_result  = acc_m ? {acc[35:20], acc[15:0]} : acc[31:0];
    assign mac_protect = acc_m ? {acc[39:36], acc[19:16]} : acc[39:32];

    typedef struct {
        logic [7:0]        len;
        logic              mode;
        logic              sat;
        logic [2:0][15:0]  a;
        logic [2:0][15:0]  b;
        logic [31:0]       exp_d;
        logic [7:0]        exp_p;
    } job_t;

    job_t tbl [8];

    function automatic job_t mk(input logic [7:0] len, input logic mode, input logic sat,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic [15:0] a2, input logic [15:0] b2,
                                input logic [31:0] ed, input logic [7:0] ep);
        job_t j;
        j.len = len; j.mode = mode; j.sat = sat;
        j.a[0] = a0; j.a[1] = a1; j.a[2] = a2;
        j.b[0] = b0; j.b[1] = b1; j.b[2] = b2;
        j.exp_d = ed; j.exp_p = ep;
        return j;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // vpat bit k gives op_valid in the k-th issue cycle (1 beyond bit 7).
    task automatic run_job(input job_t j, input logic [7:0] vpat, input int hold);
        int cyc, k, sent, exp_lat;
        cmd_valid = 1'b1; cmd_len = j.len; cmd_mode = j.mode; cmd_sat = j.sat;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cyc = 1; sent = 0; k = 0;
        while (sent < int'(j.len) && cyc < 64) begin
            op_valid = (k < 8) ? vpat[k] : 1'b1;
            op_a = j.a[sent]; op_b = j.b[sent];
            #1;
            check("op_ready", op_ready, 1);
            check("issue_stall", mac_stall, !op_valid);
            if (op_valid) begin
                check("issue_opcode", mac_instruction, (sent == 0) ? {j.mode, 2'b01} : {j.mode, 2'b10});
                check("issue_mcand", mac_multiplicand, j.a[sent]);
                check("issue_mplier", mac_multiplier, j.b[sent]);
                sent++;
            end
            tick();
            cyc++; k++;
        end
        op_valid = 1'b0; op_a = '0; op_b = '0;
        exp_lat = cyc + 3 + ((j.len == 0) ? 1 : int'(j.sat));
        while (!res_valid && cyc < 80) begin
            tick();
            cyc++;
        end
        check("res_latency", cyc, exp_lat);
        check("res_data", res_data, j.exp_d);
        check("res_protect", res_protect, j.exp_p);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1; cmd_len = 8'd0;
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, j.exp_d);
            check("hold_busy", busy, 1);
            check("hold_stall", mac_stall, 1);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("post_resp_valid", res_valid, 0);
        check("post_resp_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        bit seen;
        tbl[0] = mk(8'd3, 1'b0, 1'b0, 16'd3, 16'd4, 16'hFFFE, 16'd5, 16'd100, 16'd100, 32'h00002712, 8'h00);
        tbl[1] = mk(8'd2, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0, 16'h0, 32'h80000000, 8'h00);
        tbl[2] = mk(8'd2, 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0, 16'h0, 32'h7FFFFFFF, 8'h00);
        tbl[3] = mk(8'd3, 1'b1, 1'b1, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F, 32'h7FFF7FFF, 8'h00);
        tbl[4] = mk(8'd3, 1'b1, 1'b0, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F, 32'hBD03BD03, 8'h00);
        tbl[5] = mk(8'd1, 1'b0, 1'b0, 16'hFFFF, 16'd1, 16'h0, 16'h0, 16'h0, 16'h0, 32'hFFFFFFFF, 8'hFF);
        tbl[6] = mk(8'd1, 1'b1, 1'b0, 16'hFF02, 16'h0103, 16'h0, 16'h0, 16'h0, 16'h0, 32'hFFFF0006, 8'hF0);
        tbl[7] = mk(8'd0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 32'h00000000, 8'h00);

        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_op_ready", op_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", mac_stall, 1);
        check("rst_instr", mac_instruction, 3'b010);
        check("rst_operands", {mac_multiplier, mac_multiplicand}, 32'h0);
        check("rst_res", {res_protect, res_data}, 40'h0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_job(tbl[i], 8'hFF, 0);

        // Operand gaps: 1,0,0,1,0,1 must give the gapless result.
        run_job(tbl[0], 8'h29, 0);

        // Backpressure on the response, then an empty job right after.
        run_job(tbl[5], 8'hFF, 5);
        run_job(tbl[7], 8'hFF, 0);

        // Reset while draining aborts the job without a response.
        cmd_valid = 1'b1; cmd_len = 8'd1; cmd_mode = 1'b0; cmd_sat = 1'b0;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 16'd7; op_b = 16'd7;
        tick();
        op_valid = 1'b0;
        tick();
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_instr", mac_instruction, 3'b010);
        check("mid_rst_res", res_data, 32'h0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            seen = seen | res_valid;
        end
        check("abort_no_resp", seen, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        run_job(mk(8'd1, 1'b0, 1'b0, 16'd5, 16'd6, 16'h0, 16'h0, 16'h0, 16'h0, 32'd30, 8'h00), 8'hFF, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Job controller that drives the pipelined `mac` unit as a dot-product engine. It accepts a command (length, lane mode, saturate flag), streams operand pairs from a valid/ready source into the MAC, and stalls the MAC whenever operands are missing. It drains the three-stage MAC pipeline, then returns the captured 32-bit result and 8-bit protect bits on a valid/ready response port. It sits between the operand fetch logic and the `mac` instance and is the only agent driving the MAC's instruction and stall inputs. The system ties mac `reset_n` to `~reset`.

## Interface
- `LEN_W`, 8: width of the job length field.
- `MAC_LAT`, 3: drain cycles after the last issue before the result is captured.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_len` in LEN_W: number of operand pairs, 0..255.
- `cmd_mode` in 1: 0 = 16x16 into a 40-bit accumulator; 1 = dual 8x8 lanes.
- `cmd_sat` in 1: 1 = append a saturate instruction.
- `op_valid` in 1, `op_ready` out 1: operand handshake.
- `op_a` in 16, `op_b` in 16: operand pair.
- `mac_instruction` out 3, `mac_multiplier` out 16, `mac_multiplicand` out 16, `mac_stall` out 1: drive the MAC.
- `mac_result` in 32, `mac_protect` in 8: MAC outputs.
- `res_valid` out 1, `res_ready` in 1: response handshake.
- `res_data` out 32, `res_protect` out 8: captured result.
- `busy` out 1: state is not IDLE.

## Operation
- **Command latch:** on command acceptance, `cmd_len`, `cmd_mode` and `cmd_sat` are latched. Let `m = mode`. The MAC opcodes are:
  - LOAD = `m?101:001`
  - ACC = `m?110:010`
  - SAT = `m?111:011`
  - CLR = `m?100:000`
- **Idle issue pattern:** whenever no real instruction is issued, the outputs are ACC with `mac_multiplier = mac_multiplicand = 0`. This is a harmless "add zero", so in-flight filler never corrupts the accumulator. Opcode 000/100 is never used as a bubble.
- **FSM (registered):**
  - **IDLE:**
    - `cmd_ready = 1`, `mac_stall = 1`.
    - Command accepted: if len = 0, go to CLRS; otherwise go to ISSUE with `cnt = 0`.
  - **ISSUE:** `op_ready = 1`, `mac_stall = !op_valid`.
    - Each transferred pair drives `mac_multiplicand = op_a` and `mac_multiplier = op_b`.
    - The opcode is LOAD when `cnt == 0`, otherwise ACC; `cnt` increments.
    - If the pair is the last one (`cnt == len-1`), go to SATS when `sat = 1`, otherwise go to DRAIN.
    - While `op_valid = 0`, the MAC is frozen and the presented instruction is ignored.
  - **CLRS:** issue CLR for one cycle unstalled, then go to DRAIN.
  - **SATS:** issue SAT for one cycle unstalled, then go to DRAIN.
  - **DRAIN:**
    - Issue zero-ACC unstalled for MAC_LAT cycles.
    - On the edge ending the last drain cycle, capture `res_data <= mac_result` and `res_protect <= mac_protect`, then go to RESP.
  - **RESP:**
    - `res_valid = 1`, `mac_stall = 1`.
    - Data is held stable until `res_ready`; then go to IDLE.
- **Arithmetic:** this block performs none. Result and protect are copied bit-exact from the MAC. Filler zero-ACCs left in the pipeline retire ahead of the next LOAD.
- **Reset (any time, including mid-job):**
  - Go to IDLE and abort the job; no response is produced.
  - `cnt`, `res_data` and `res_protect` clear to 0.
  - `res_valid = 0`, `op_ready = 0`, `cmd_ready = 1`, `mac_stall = 1`, `busy = 0`.
  - `mac_instruction` = 010 with zero operands.

## Timing
- Command accepted at edge C: the first issue (LOAD) is possible in the cycle after C. `op_ready` is combinational on state only; `op_valid` never combinationally gates `op_ready`.
- Last real issue (final pair, SAT or CLR) in cycle L:
  - DRAIN occupies L+1..L+3.
  - Capture happens on the edge ending L+3.
  - `res_valid` is high from cycle L+4.
- Back-to-back pairs with `op_valid` held high: one pair per cycle, len=N completes with `res_valid` at command edge + N + 4 (+1 with sat).
- Response handshake in cycle R: `cmd_ready` is high in R+1. A new command can be accepted in R+1, and its LOAD is issued in R+2.
- `cmd_valid` during a busy job is ignored, not queued.
- `res_ready` held low keeps RESP with `res_data` constant and `mac_stall = 1` indefinitely.

## Test plan
- **16-bit dot product:** mode 0, len 3, pairs (3,4), (-2,5), (100,100), sat 0 -> `res_data` = 10002 (0x00002712), `res_protect` = 0x00, `res_valid` 7 cycles after command acceptance.
- **Saturation vs. no saturation:** mode 0, len 2, pairs (-32768,-32768) x2.
  - sat 0 -> `res_data` = 0x80000000, `res_protect` = 0x00.
  - sat 1 -> `res_data` = 0x7FFFFFFF.
- **Dual-lane saturation:** mode 1, len 3, `op_a` = `op_b` = 0x7F7F each pair, sat 1 -> both lanes 48387 clip, `res_data` = 0x7FFF7FFF.
- **Operand gaps:** `op_valid` toggled 1,0,0,1,0,1 across a len-3 job -> `mac_stall` high exactly in the gap cycles, same result as the gapless run.
- **Response backpressure and empty job:** `res_ready` held low 5 cycles -> `res_data` stable, `busy` = 1. Then a len 0 command -> CLR issued, `res_data` = 0, `res_protect` = 0.
- **Mid-job reset:** assert `reset` during DRAIN -> no `res_valid`, `cmd_ready` = 1 after release. The next len-1 job (5,6) returns 30.
